// File: rtl/qspi2sdram_pkg.sv
// Shared state encoding, defaults and buffer helper for the QSPI staging RAM to
// SDRAM burst writer.
package qspi2sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } wr_state_e;

  localparam int ADDR_W_DEF    = 24;
  localparam int DATA_W_DEF    = 16;
  localparam int BURST_LEN_DEF = 8;
  localparam int WBUF_DEPTH    = 2;

  // Words the buffer will hold once this cycle's pop and the read now returning settle.
  function automatic logic [2:0] wbuf_occupancy(input logic [1:0] count,
                                                input logic       inflight,
                                                input logic       pop);
    wbuf_occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/qspi_sdram_wbuf.sv
// Two-entry prefetch buffer between the staging RAM read port and the SDRAM
// write-data port; head is presented combinationally on rdata.
module qspi_sdram_wbuf
  import qspi2sdram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) begin
          slot1 <= wdata;
        end else begin
          slot0 <= wdata;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = rd_ptr ? slot1 : slot0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/qspi_sdram_wr.sv
// Moves one staged burst from the QSPI staging RAM to the SDRAM write port,
// prefetching through a 2-entry buffer so XFER sustains one word per cycle.
module qspi_sdram_wr
  import qspi2sdram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int RAM_AW    = 3
) (
  input  logic              qspi_clk,
  input  logic              rst,
  input  logic              qspi_wr_req,
  input  logic [ADDR_W-1:0] qspi_wr_addr,
  output logic              ram_ren,
  output logic [RAM_AW-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              sdram_wr_req,
  input  logic              sdram_wr_ack,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [DATA_W-1:0] sdram_wr_data,
  output logic              sdram_wr_dvld,
  input  logic              sdram_wr_drdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [RAM_AW:0] BURST_CNT = (RAM_AW + 1)'(BURST_LEN);
  localparam logic [RAM_AW:0] LAST_WORD = BURST_CNT - {{RAM_AW{1'b0}}, 1'b1};

  wr_state_e         state;
  wr_state_e         state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [RAM_AW:0]   rd_cnt;
  logic [RAM_AW:0]   word_cnt;
  logic              inflight;
  logic              req_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              drop;
  logic              handshake;
  logic              last_word;
  logic              rd_active;
  logic [2:0]        occupancy;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign accept    = qspi_wr_req & ((state == ST_IDLE) | (state == ST_DONE));
  assign drop      = qspi_wr_req & ((state == ST_REQ) | (state == ST_XFER));
  assign handshake = sdram_wr_dvld & sdram_wr_drdy;
  assign last_word = handshake & (word_cnt == LAST_WORD);
  assign rd_active = (state == ST_REQ) | (state == ST_XFER);
  assign occupancy = wbuf_occupancy(fifo_count, inflight, handshake);

  // Prefetch keeps at most two words buffered or in flight, counting the word leaving now.
  assign ram_ren = rd_active & (rd_cnt < BURST_CNT) & (occupancy < 3'(WBUF_DEPTH))
                 & (~fifo_full | handshake);
  assign ram_raddr = rd_cnt[RAM_AW-1:0];

  assign sdram_wr_dvld = (state == ST_XFER) & ~fifo_empty;
  assign sdram_wr_data = fifo_head;
  assign sdram_wr_addr = addr_q;
  assign sdram_wr_req  = req_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (qspi_wr_req) begin
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (sdram_wr_ack) begin
          state_nxt = ST_XFER;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_XFER: begin
        if (last_word) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_XFER;
        end
      end
      ST_DONE: begin
        if (qspi_wr_req) begin
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and output flags derived from the state being entered.
  always_ff @(posedge qspi_clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_q  <= (state_nxt == ST_REQ);
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= (state_nxt == ST_DONE);
    end
  end

  // Burst address, read/word counters and the one-cycle read pipeline tag.
  always_ff @(posedge qspi_clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      rd_cnt   <= '0;
      word_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= ram_ren;
      if (accept) begin
        addr_q   <= qspi_wr_addr;
        rd_cnt   <= '0;
        word_cnt <= '0;
      end else begin
        if (ram_ren) begin
          rd_cnt <= rd_cnt + {{RAM_AW{1'b0}}, 1'b1};
        end
        if (handshake) begin
          word_cnt <= word_cnt + {{RAM_AW{1'b0}}, 1'b1};
        end
      end
    end
  end

  // Sticky drop flag; a drop wins over a simultaneous clear.
  always_ff @(posedge qspi_clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (drop) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q;
    end
  end

  qspi_sdram_wbuf #(
    .DATA_W(DATA_W)
  ) u_wbuf (
    .clk  (qspi_clk),
    .rst  (rst),
    .push (inflight),
    .wdata(ram_rdata),
    .pop  (handshake),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_qspi_sdram_wr.sv
// Bench for qspi_sdram_wr: a burst-level reference model checked every cycle,
// directed scenarios with literal expectations, and randomized bursts.
module tb_qspi_sdram_wr;

  localparam int BL = 8;

  logic        clk;
  logic        rst;
  logic        qspi_wr_req;
  logic [23:0] qspi_wr_addr;
  logic        ram_ren;
  logic [2:0]  ram_raddr;
  logic [15:0] ram_rdata;
  logic        sdram_wr_req;
  logic        sdram_wr_ack;
  logic [23:0] sdram_wr_addr;
  logic [15:0] sdram_wr_data;
  logic        sdram_wr_dvld;
  logic        sdram_wr_drdy;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [BL];

  // Reference model: burst phase (0 idle, 1 request, 2 transfer, 3 done), words accepted, reads issued.
  int          m_phase = 0;
  logic [23:0] m_addr = '0;
  int          m_words = 0;
  logic        m_err = 1'b0;
  int          m_rd = 0;

  int          n_hs = 0;
  int          n_done = 0;
  logic [15:0] hs_q [$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  int   drdy_mode = 0;
  int   ack_fixed = 0;
  logic spur_ack = 1'b0;

  qspi_sdram_wr dut (
    .qspi_clk     (clk),
    .rst          (rst),
    .qspi_wr_req  (qspi_wr_req),
    .qspi_wr_addr (qspi_wr_addr),
    .ram_ren      (ram_ren),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .sdram_wr_req (sdram_wr_req),
    .sdram_wr_ack (sdram_wr_ack),
    .sdram_wr_addr(sdram_wr_addr),
    .sdram_wr_data(sdram_wr_data),
    .sdram_wr_dvld(sdram_wr_dvld),
    .sdram_wr_drdy(sdram_wr_drdy),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Staging RAM: one-cycle read latency, junk on idle cycles.
  always @(posedge clk) begin
    ram_rdata <= ram_ren ? mem[ram_raddr] : 16'($urandom);
  end

  // Burst-level reference model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_addr  <= '0;
      m_words <= 0;
      m_err   <= 1'b0;
      m_rd    <= 0;
    end else begin
      if (ram_ren) m_rd <= m_rd + 1;
      if (qspi_wr_req && (m_phase == 1 || m_phase == 2)) m_err <= 1'b1;
      else if (err_clr) m_err <= 1'b0;
      case (m_phase)
        0, 3: begin
          if (qspi_wr_req) begin
            m_phase <= 1;
            m_addr  <= qspi_wr_addr;
            m_words <= 0;
            m_rd    <= 0;
          end else begin
            m_phase <= 0;
          end
        end
        1: if (sdram_wr_ack) m_phase <= 2;
        2: begin
          if (sdram_wr_drdy) begin
            m_words <= m_words + 1;
            if (m_words == BL - 1) m_phase <= 3;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("wr_req", 32'(sdram_wr_req), 32'(m_phase == 1));
    chk("dvld", 32'(sdram_wr_dvld), 32'(m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("err", 32'(err), 32'(m_err));
    chk("addr", 32'(sdram_wr_addr), 32'(m_addr));
    if (m_phase == 2) chk("data", 32'(sdram_wr_data), 32'(mem[m_words]));
    if (ram_ren) begin
      chk("raddr", 32'(ram_raddr), 32'(m_rd));
      chk("rd_in_burst", 32'((m_phase == 1 || m_phase == 2) && m_rd < BL), 32'd1);
    end
    if (rst) begin
      chk("rst_ren", 32'(ram_ren), 32'd0);
      chk("rst_raddr", 32'(ram_raddr), 32'd0);
    end
    if (prev_stall && sdram_wr_dvld) chk("stall_hold", 32'(sdram_wr_data), 32'(prev_data));
    prev_stall <= sdram_wr_dvld && !sdram_wr_drdy && !rst;
    prev_data  <= sdram_wr_data;
    if (done) n_done <= n_done + 1;
    if (sdram_wr_dvld && sdram_wr_drdy) begin
      n_hs <= n_hs + 1;
      hs_q.push_back(sdram_wr_data);
    end
  end

  // SDRAM controller side: ack after a delay in REQ, drdy by pattern.
  initial begin
    int req_cyc = 0;
    int x_cyc = 0;
    int ack_dly = 3;
    sdram_wr_ack  = 1'b0;
    sdram_wr_drdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (m_phase == 1) req_cyc++; else req_cyc = 0;
      if (req_cyc == 1) ack_dly = (ack_fixed != 0) ? ack_fixed : int'($urandom_range(5, 2));
      if (m_phase == 2) x_cyc++; else x_cyc = 0;
      sdram_wr_ack = ((m_phase == 1) && (req_cyc == ack_dly)) || spur_ack;
      case (drdy_mode)
        0:       sdram_wr_drdy = 1'b1;
        1:       sdram_wr_drdy = ((x_cyc % 3) == 1);
        default: sdram_wr_drdy = 1'($urandom_range(1, 0));
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [23:0] a);
    qspi_wr_req  = 1'b1;
    qspi_wr_addr = a;
    cyc();
    qspi_wr_req  = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_phase", 32'(m_phase), 32'(ph));
  endtask

  initial begin
    int base;
    int d0;
    int n;
    rst = 1'b1;
    qspi_wr_req = 1'b0;
    qspi_wr_addr = '0;
    err_clr = 1'b0;
    for (int i = 0; i < BL; i++) mem[i] = '0;
    repeat (3) cyc();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_addr", 32'(sdram_wr_addr), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    cyc();

    // Spurious ack in IDLE
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    cyc();
    cyc();
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_dvld", 32'(sdram_wr_dvld), 32'd0);

    // Basic burst
    for (int i = 0; i < BL; i++) mem[i] = 16'h1000 + 16'(i);
    drdy_mode = 0;
    ack_fixed = 3;
    base = n_hs;
    d0 = n_done;
    start(24'h000040);
    chk("basic_addr", 32'(sdram_wr_addr), 32'h0000_0040);
    wait_phase(0, 40);
    chk("basic_count", 32'(hs_q.size() - base), 32'd8);
    for (int i = 0; i < BL; i++) chk("basic_data", 32'(hs_q[base + i]), 32'h1000 + 32'(i));
    chk("basic_done", 32'(n_done - d0), 32'd1);
    chk("basic_busy", 32'(busy), 32'd0);

    // Back-pressure
    for (int i = 0; i < BL; i++) mem[i] = 16'($urandom);
    drdy_mode = 1;
    ack_fixed = 0;
    base = n_hs;
    start(24'($urandom));
    wait_phase(0, 100);
    chk("bp_handshakes", 32'(n_hs - base), 32'd8);

    // Request while busy, with err_clr in the same cycle
    drdy_mode = 0;
    d0 = n_done;
    start(24'h000100);
    wait_phase(2, 20);
    cyc();
    qspi_wr_req = 1'b1;
    qspi_wr_addr = 24'h123456;
    err_clr = 1'b1;
    cyc();
    qspi_wr_req = 1'b0;
    err_clr = 1'b0;
    chk("busy_err", 32'(err), 32'd1);
    chk("busy_addr", 32'(sdram_wr_addr), 32'h0000_0100);
    wait_phase(0, 40);
    chk("busy_done", 32'(n_done - d0), 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);

    // Request in the DONE cycle
    d0 = n_done;
    start(24'h000200);
    wait_phase(3, 40);
    qspi_wr_req = 1'b1;
    qspi_wr_addr = 24'h000080;
    cyc();
    qspi_wr_req = 1'b0;
    chk("chain_addr", 32'(sdram_wr_addr), 32'h0000_0080);
    chk("chain_busy", 32'(busy), 32'd1);
    wait_phase(0, 40);
    chk("chain_err", 32'(err), 32'd0);
    chk("chain_dones", 32'(n_done - d0), 32'd2);

    // Mid-burst reset
    d0 = n_done;
    base = n_hs;
    start(24'h000300);
    n = 0;
    while (n_hs < base + 3 && n < 30) begin
      cyc();
      n++;
    end
    chk("mid_words", 32'(n_hs >= base + 3), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_req", 32'(sdram_wr_req), 32'd0);
    chk("mid_dvld", 32'(sdram_wr_dvld), 32'd0);
    chk("mid_ren", 32'(ram_ren), 32'd0);
    chk("mid_addr", 32'(sdram_wr_addr), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("mid_no_done", 32'(n_done - d0), 32'd0);
    base = n_hs;
    start(24'h000400);
    wait_phase(0, 40);
    chk("post_rst_words", 32'(n_hs - base), 32'd8);
    chk("post_rst_done", 32'(n_done - d0), 32'd1);

    // Randomized bursts with stray requests and clears
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < BL; i++) mem[i] = 16'($urandom);
      drdy_mode = 2;
      ack_fixed = 0;
      start(24'($urandom));
      n = 0;
      while (m_phase != 0 && n < 200) begin
        qspi_wr_req  = ($urandom_range(15, 0) == 0);
        qspi_wr_addr = 24'($urandom);
        err_clr      = ($urandom_range(7, 0) == 0);
        cyc();
        n++;
      end
      qspi_wr_req = 1'b0;
      err_clr = 1'b0;
      chk("rand_idle", 32'(m_phase), 32'd0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
